// File: rtl/cla_pipelined_addsub.sv
// Pipelined carry-lookahead adder/subtractor.
// The operands are split into GROUP-bit lookahead groups and one group is
// resolved per pipeline stage. The carry between groups only crosses a
// register, so a result appears NG = WIDTH/GROUP cycles after it is accepted,
// at one operation per cycle. One global advance signal moves or freezes the
// whole pipe, and the last stage register is the output register.
module cla_pipelined_addsub #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg,
    output logic [TAG_W-1:0] out_tag
);

    localparam int NG = WIDTH / GROUP;

    // The group size must divide the operand width exactly.
    if (GROUP < 1 || (WIDTH % GROUP) != 0) begin : g_bad_params
        $error("cla_pipelined_addsub: WIDTH (%0d) must be a multiple of GROUP (%0d)", WIDTH, GROUP);
    end

    // One pipeline slot. The operand fields hold the effective operands, so
    // the subtract inversion happens once at the input. The bits a stage has
    // not consumed yet travel along with it (input skew). res fills up from
    // the LSB, one group per stage. carry is the carry out of the highest
    // group resolved so far; cmsb is the carry into that group's top bit,
    // which becomes the carry into bit WIDTH-1 in the last stage.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
        logic             carry;
        logic             cmsb;
    } stage_t;

    // Result of one lookahead group.
    typedef struct packed {
        logic [GROUP-1:0] sum;
        logic             cout;
        logic             cmsb;
    } grp_t;

    // GROUP-bit generate/propagate lookahead. Every internal carry is built
    // as a flat sum of products of g, p and the group carry-in:
    //   c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[1]g[0] | p[i]..p[0]cin
    function automatic grp_t cla_group(
        input logic [GROUP-1:0] a,
        input logic [GROUP-1:0] b,
        input logic             cin
    );
        grp_t             r;
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   c;
        logic             term;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < GROUP; i++) begin
            // Carry-in propagated through every bit up to i.
            c[i+1] = cin;
            for (int j = 0; j <= i; j++) begin
                c[i+1] = c[i+1] & p[j];
            end
            // Generate at bit j propagated through bits j+1..i.
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    term = term & p[m];
                end
                c[i+1] = c[i+1] | term;
            end
        end
        r.sum  = p ^ c[GROUP-1:0];
        r.cout = c[GROUP];
        r.cmsb = c[GROUP-1];
        return r;
    endfunction

    stage_t st_q [NG];
    stage_t st_d [NG];
    stage_t src  [NG];
    grp_t   grp  [NG];
    logic   zero_q;
    logic   zero_d;
    logic   adv;

    // The whole pipe moves unless a finished result is waiting for the consumer.
    assign adv      = !st_q[NG-1].valid || out_ready;
    assign in_ready = adv;

    // Next state of every stage: take the previous slot (stage 0 takes the
    // conditioned inputs) and resolve this stage's group from its registered carry.
    always_comb begin
        // NOTE: every variable written here gets a full default first, so no
        // path can leave one unassigned and infer a latch.
        src[0].valid = in_valid;
        src[0].tag   = in_tag;
        src[0].a     = in_a;
        src[0].b     = in_b ^ {WIDTH{in_sub}};
        src[0].res   = '0;
        src[0].carry = in_cin ^ in_sub;
        src[0].cmsb  = 1'b0;
        for (int k = 1; k < NG; k++) begin
            src[k] = st_q[k-1];
        end
        for (int k = 0; k < NG; k++) begin
            grp[k]  = cla_group(src[k].a[k*GROUP +: GROUP],
                                src[k].b[k*GROUP +: GROUP],
                                src[k].carry);
            st_d[k] = src[k];
            st_d[k].res[k*GROUP +: GROUP] = grp[k].sum;
            st_d[k].carry = grp[k].cout;
            st_d[k].cmsb  = grp[k].cmsb;
        end
        zero_d = (st_d[NG-1].res == '0);
    end

    // Stage registers: clear on reset, shift together on advance, hold otherwise.
    always_ff @(posedge clk) begin
        // NOTE: the data fields are reset as well as the valid bits, because
        // the last stage drives the outputs directly and they must read 0
        // after reset.
        if (reset) begin
            for (int k = 0; k < NG; k++) begin
                st_q[k] <= '0;
            end
            zero_q <= 1'b0;
        end else if (adv) begin
            // NOTE: non-blocking assignments let every stage capture its
            // predecessor's old value on the same edge.
            for (int k = 0; k < NG; k++) begin
                st_q[k] <= st_d[k];
            end
            zero_q <= zero_d;
        end
    end

    assign out_valid  = st_q[NG-1].valid;
    assign out_result = st_q[NG-1].res;
    assign out_cout   = st_q[NG-1].carry;
    assign out_ovf    = st_q[NG-1].carry ^ st_q[NG-1].cmsb;
    assign out_zero   = zero_q;
    assign out_neg    = st_q[NG-1].res[WIDTH-1];
    assign out_tag    = st_q[NG-1].tag;

endmodule

// File: tb/tb_cla_pipelined_addsub.sv
// Bench for cla_pipelined_addsub: three instances (16/4, 32/8, 8/8).
// Instance 0 gets directed cases, backpressure, mid-stream reset and random
// traffic; instances 1 and 2 get long random streams. Expected results are
// queued at acceptance and compared by a monitor whenever out_valid is high.
module tb_cla_pipelined_addsub;

    typedef struct {
        logic [31:0] res;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
        logic [3:0]  tag;
        int          stamp;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i       [3];
    logic        in_valid_i  [3];
    logic [31:0] a_i         [3];
    logic [31:0] b_i         [3];
    logic        cin_i       [3];
    logic        sub_i       [3];
    logic [3:0]  tag_i       [3];
    logic        out_ready_i [3];
    logic        in_ready_o  [3];
    logic        out_valid_o [3];
    logic [31:0] res_o       [3];
    logic        cout_o      [3];
    logic        ovf_o       [3];
    logic        zero_o      [3];
    logic        neg_o       [3];
    logic [3:0]  tag_o       [3];

    logic [15:0] res0;
    logic [31:0] res1;
    logic [7:0]  res2;
    assign res_o[0] = {16'd0, res0};
    assign res_o[1] = res1;
    assign res_o[2] = {24'd0, res2};

    cla_pipelined_addsub #(.WIDTH(16), .GROUP(4), .TAG_W(4)) u_dut16 (
        .clk(clk), .reset(rst_i[0]), .in_valid(in_valid_i[0]), .in_ready(in_ready_o[0]),
        .in_a(a_i[0][15:0]), .in_b(b_i[0][15:0]), .in_cin(cin_i[0]), .in_sub(sub_i[0]),
        .in_tag(tag_i[0]), .out_valid(out_valid_o[0]), .out_ready(out_ready_i[0]),
        .out_result(res0), .out_cout(cout_o[0]), .out_ovf(ovf_o[0]), .out_zero(zero_o[0]),
        .out_neg(neg_o[0]), .out_tag(tag_o[0])
    );

    cla_pipelined_addsub #(.WIDTH(32), .GROUP(8), .TAG_W(4)) u_dut32 (
        .clk(clk), .reset(rst_i[1]), .in_valid(in_valid_i[1]), .in_ready(in_ready_o[1]),
        .in_a(a_i[1]), .in_b(b_i[1]), .in_cin(cin_i[1]), .in_sub(sub_i[1]),
        .in_tag(tag_i[1]), .out_valid(out_valid_o[1]), .out_ready(out_ready_i[1]),
        .out_result(res1), .out_cout(cout_o[1]), .out_ovf(ovf_o[1]), .out_zero(zero_o[1]),
        .out_neg(neg_o[1]), .out_tag(tag_o[1])
    );

    cla_pipelined_addsub #(.WIDTH(8), .GROUP(8), .TAG_W(4)) u_dut8 (
        .clk(clk), .reset(rst_i[2]), .in_valid(in_valid_i[2]), .in_ready(in_ready_o[2]),
        .in_a(a_i[2][7:0]), .in_b(b_i[2][7:0]), .in_cin(cin_i[2]), .in_sub(sub_i[2]),
        .in_tag(tag_i[2]), .out_valid(out_valid_o[2]), .out_ready(out_ready_i[2]),
        .out_result(res2), .out_cout(cout_o[2]), .out_ovf(ovf_o[2]), .out_zero(zero_o[2]),
        .out_neg(neg_o[2]), .out_tag(tag_o[2])
    );

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb [3][$];
    int   adv_cnt    [3];
    bit   shown      [3];
    int   ready_mode [3];   // 0: always ready, 1: toggle, 2: random
    bit   dir_use;
    exp_t dir_exp;

    function automatic int w_of(int i);
        return (i == 0) ? 16 : (i == 1) ? 32 : 8;
    endfunction

    function automatic int ng_of(int i);
        return (i == 2) ? 1 : 4;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: modulo arithmetic for result/carry, signed integer range
    // test for overflow.
    function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b,
                                   logic cin, logic sub, logic [3:0] tag);
        exp_t e;
        longint unsigned mask, am, bm, full;
        longint sa, sbv, s, half;
        mask = (64'd1 << w) - 64'd1;
        am   = 64'(a) & mask;
        bm   = 64'(sub ? ~b : b) & mask;
        full = am + bm + 64'(cin ^ sub);
        half = longint'(64'd1 << (w - 1));
        sa   = (am  >= 64'(half)) ? longint'(am) - 2 * half : longint'(am);
        sbv  = (bm  >= 64'(half)) ? longint'(bm) - 2 * half : longint'(bm);
        s    = sa + sbv + longint'(cin ^ sub);
        e.res   = 32'(full & mask);
        e.cout  = ((full >> w) & 64'd1) != 0;
        e.ovf   = (s >= half) || (s < -half);
        e.zero  = (e.res == 32'd0);
        e.neg   = e.res[w-1];
        e.tag   = tag;
        e.stamp = 0;
        return e;
    endfunction

    function automatic exp_t mk(logic [31:0] res, logic cout, logic ovf,
                                logic zero, logic neg, logic [3:0] tag);
        exp_t e;
        e.res = res; e.cout = cout; e.ovf = ovf; e.zero = zero; e.neg = neg;
        e.tag = tag; e.stamp = 0;
        return e;
    endfunction

    // Consumer side readiness.
    always begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            case (ready_mode[i])
                0:       out_ready_i[i] = 1'b1;
                1:       out_ready_i[i] = !out_ready_i[i];
                default: out_ready_i[i] = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        logic adv;
        for (int i = 0; i < 3; i++) begin
            if (rst_i[i]) begin
                sb[i].delete();
                shown[i] = 1'b0;
            end else begin
                adv = !out_valid_o[i] || out_ready_i[i];
                check($sformatf("in_ready[%0d]", i), 64'(in_ready_o[i]), 64'(adv));
                if (out_valid_o[i]) begin
                    if (sb[i].size() == 0) begin
                        check($sformatf("unexpected_out_valid[%0d]", i), 64'(out_valid_o[i]), 64'd0);
                    end else begin
                        e = sb[i][0];
                        if (!shown[i]) begin
                            check($sformatf("latency[%0d]", i), 64'(adv_cnt[i] - e.stamp), 64'(ng_of(i)));
                            shown[i] = 1'b1;
                        end
                        check($sformatf("result{tag,neg,zero,ovf,cout,res}[%0d]", i),
                              {tag_o[i], neg_o[i], zero_o[i], ovf_o[i], cout_o[i], res_o[i]},
                              {e.tag, e.neg, e.zero, e.ovf, e.cout, e.res});
                        if (out_ready_i[i]) begin
                            void'(sb[i].pop_front());
                            shown[i] = 1'b0;
                        end
                    end
                end
                if (in_valid_i[i] && in_ready_o[i]) begin
                    if (i == 0 && dir_use) e = dir_exp;
                    else e = model(w_of(i), a_i[i], b_i[i], cin_i[i], sub_i[i], tag_i[i]);
                    e.stamp = adv_cnt[i];
                    sb[i].push_back(e);
                end
                if (adv) adv_cnt[i]++;
            end
        end
    end

    task automatic check_reset_state(int i);
        check($sformatf("reset_out_valid[%0d]", i), 64'(out_valid_o[i]), 64'd0);
        check($sformatf("reset_outputs[%0d]", i),
              {tag_o[i], neg_o[i], zero_o[i], ovf_o[i], cout_o[i], res_o[i]}, 64'd0);
        check($sformatf("reset_in_ready[%0d]", i), 64'(in_ready_o[i]), 64'd1);
    endtask

    // Present one op on instance 0 and hold it until accepted.
    task automatic send0(logic [31:0] a, logic [31:0] b, logic cin, logic sub,
                         logic [3:0] tag, bit use_dir, exp_t e);
        int n;
        @(posedge clk);
        #1;
        in_valid_i[0] = 1'b1;
        a_i[0] = a; b_i[0] = b; cin_i[0] = cin; sub_i[0] = sub; tag_i[0] = tag;
        dir_use = use_dir;
        dir_exp = e;
        n = 0;
        @(negedge clk);
        while (!in_ready_o[0] && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready_o[0]) check("send0_accept_timeout", 64'(in_ready_o[0]), 64'd1);
    endtask

    task automatic idle0();
        @(posedge clk);
        #1;
        in_valid_i[0] = 1'b0;
        dir_use = 1'b0;
    endtask

    task automatic wait_drain(int i);
        int n;
        n = 0;
        while (sb[i].size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb[i].size() != 0) check($sformatf("drain[%0d]", i), 64'(sb[i].size()), 64'd0);
    endtask

    task automatic sweep(int i, int n_ops);
        int acc;
        int cyc;
        logic [31:0] msb;
        acc = 0;
        cyc = 0;
        msb = 32'd1 << (w_of(i) - 1);
        ready_mode[i] = 2;
        while (acc < n_ops && cyc < n_ops * 10) begin
            @(posedge clk);
            #1;
            in_valid_i[i] = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       a_i[i] = 32'd0;
                1:       a_i[i] = 32'hFFFF_FFFF;
                2:       a_i[i] = msb;
                3:       a_i[i] = msb - 32'd1;
                default: a_i[i] = $urandom;
            endcase
            b_i[i]   = ($urandom_range(0, 7) == 0) ? 32'd1 : $urandom;
            cin_i[i] = $urandom_range(0, 1) == 1;
            sub_i[i] = $urandom_range(0, 1) == 1;
            tag_i[i] = 4'($urandom);
            @(negedge clk);
            if (in_valid_i[i] && in_ready_o[i]) acc++;
            cyc++;
        end
        @(posedge clk);
        #1;
        in_valid_i[i] = 1'b0;
        ready_mode[i] = 0;
        if (acc < n_ops) check($sformatf("sweep_accepts[%0d]", i), 64'(acc), 64'(n_ops));
    endtask

    task automatic test0();
        exp_t z;
        z = mk(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        ready_mode[0] = 0;
        // Basic add and latency.
        send0(32'h1234, 32'h4321, 1'b0, 1'b0, 4'd3, 1'b1, mk(32'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3));
        idle0();
        wait_drain(0);
        // Full carry chain, subtract, borrow-in, overflow.
        send0(32'hFFFF, 32'h0001, 1'b0, 1'b0, 4'd5, 1'b1, mk(32'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'd5));
        send0(32'h7FFF, 32'h0001, 1'b0, 1'b0, 4'd6, 1'b1, mk(32'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 4'd6));
        send0(32'h0005, 32'h0007, 1'b0, 1'b1, 4'd7, 1'b1, mk(32'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7));
        send0(32'h0005, 32'h0003, 1'b1, 1'b1, 4'd8, 1'b1, mk(32'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8));
        send0(32'h8000, 32'h0001, 1'b0, 1'b1, 4'd9, 1'b1, mk(32'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, 4'd9));
        idle0();
        wait_drain(0);
        // Streaming with toggling backpressure.
        ready_mode[0] = 1;
        for (int t = 0; t < 8; t++) begin
            send0($urandom, $urandom, 1'($urandom), 1'($urandom), 4'(t), 1'b0, z);
        end
        idle0();
        wait_drain(0);
        ready_mode[0] = 0;
        repeat (2) @(posedge clk);
        // Reset with three operations in flight.
        for (int t = 0; t < 3; t++) begin
            send0($urandom, $urandom, 1'b0, 1'b0, 4'(10 + t), 1'b0, z);
        end
        @(posedge clk);
        #1;
        in_valid_i[0] = 1'b0;
        rst_i[0] = 1'b1;
        @(posedge clk);
        #1;
        rst_i[0] = 1'b0;
        @(negedge clk);
        check_reset_state(0);
        repeat (6) @(negedge clk);
        send0(32'h00F0, 32'h0F0F, 1'b1, 1'b0, 4'd14, 1'b1, mk(32'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd14));
        idle0();
        wait_drain(0);
        // Random traffic on the default configuration.
        sweep(0, 600);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        dir_use = 1'b0;
        dir_exp = mk(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            rst_i[i] = 1'b1; in_valid_i[i] = 1'b0; a_i[i] = '0; b_i[i] = '0;
            cin_i[i] = 1'b0; sub_i[i] = 1'b0; tag_i[i] = '0; out_ready_i[i] = 1'b1;
            ready_mode[i] = 0; adv_cnt[i] = 0; shown[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rst_i[i] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) check_reset_state(i);
        fork
            test0();
            sweep(1, 10000);
            sweep(2, 10000);
        join
        for (int i = 0; i < 3; i++) wait_drain(i);
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cla_pipelined_addsub.md
Name: cla_pipelined_addsub

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor for the datapath.
- Operands are split into GROUP-bit CLA groups, one group per pipeline stage; each stage's carry-out is registered into the next stage.
- Carries ripple between groups only through registers, so the result emerges after NG = WIDTH/GROUP cycles at one operation per cycle.
- Adds subtract mode, carry/borrow-in, status flags, tag passthrough and valid/ready flow control.

Parameters:
- WIDTH, 16: operand/result width in bits; must be a multiple of GROUP.
- GROUP, 4: bits per CLA group, which is also bits resolved per pipeline stage; must be at least 1.
- TAG_W, 4: width of the sideband tag carried alongside each operation.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block accepts the operation this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in for add; borrow-in (active-high) for subtract.
- in_sub  in  1  0 = add, 1 = subtract.
- in_tag  in  TAG_W  sideband tag, returned unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_result  out  WIDTH  sum/difference.
- out_cout  out  1  carry out of the MSB; for subtract, 1 = no borrow.
- out_ovf  out  1  signed overflow.
- out_zero  out  1  out_result == 0.
- out_neg  out  1  out_result[WIDTH-1].
- out_tag  out  TAG_W  tag of this result.

Behaviour:
- Arithmetic is modulo 2^WIDTH:
  - beff = in_b XOR {WIDTH{in_sub}}
  - c0 = in_cin XOR in_sub
  - result = in_a + beff + c0
  - sub with cin=0 gives A-B; sub with cin=1 gives A-B-1.
- Stage k (0..NG-1):
  - Computes result bits [k*GROUP +: GROUP] with a GROUP-bit generate/propagate lookahead, using the registered carry from stage k-1 (stage 0 uses c0).
  - Registers the partial result, its carry-out, and the not-yet-consumed operand bits (input skew), plus the valid bit and tag.
- Flags are computed from the final stage:
  - out_cout = carry out of bit WIDTH-1.
  - out_ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - out_zero and out_neg come from the completed out_result.
- Flow control uses a global advance: adv = !out_valid || out_ready.
  - in_ready = adv (combinational).
  - An operation is accepted when in_valid && in_ready.
  - When adv = 0, every stage register holds.
  - When adv = 1, every stage shifts by one; an empty input slot enters as a bubble (valid = 0).
- Latency: NG cycles from the accept edge to out_valid when unstalled. Throughput is one operation per cycle.
  - Bubbles are not compressed; a stall freezes the whole pipe.
- While out_valid && !out_ready, all out_* signals are held stable.
- Results leave in acceptance order with their tags intact. No loss or duplication.
- Reset (synchronous, active-high, clk edge with reset = 1):
  - All stage valid bits, out_valid, out_result, out_cout, out_ovf, out_zero, out_neg and out_tag are cleared to 0.
  - Inputs are ignored during reset.
  - The first cycle after reset has in_ready = 1.
- Reset mid-operation discards every in-flight operation. No result from before reset may appear afterwards.
- Simultaneous accept and emit (adv = 1, in_valid = 1, out_valid = 1, out_ready = 1) is legal and sustains full throughput.
- Elaboration fails (or an assertion fires) if WIDTH % GROUP != 0.
- NG = 1 degenerates to a single-stage registered adder with latency 1.

Test Plan (WIDTH=16, GROUP=4 unless stated):
1. Basic add with latency check:
   - Stimulus: add 0x1234 + 0x4321, cin=0, tag=3.
   - Required: out_valid exactly 4 cycles after accept; result 0x5555, cout=0, ovf=0, zero=0, neg=0, tag=3.
2. Full carry chain across every stage:
   - Stimulus: add 0xFFFF + 0x0001.
   - Required: result 0x0000, cout=1, zero=1, ovf=0.
   - Stimulus: add 0x7FFF + 0x0001.
   - Required: result 0x8000, ovf=1, neg=1, cout=0.
3. Subtract and borrow-in:
   - Stimulus: sub 0x0005 - 0x0007, cin=0.
   - Required: result 0xFFFE, cout=0, neg=1.
   - Stimulus: sub 0x0005 - 0x0003, cin=1.
   - Required: result 0x0001, cout=1.
   - Stimulus: sub 0x8000 - 0x0001.
   - Required: result 0x7FFF, ovf=1.
4. Streaming with backpressure:
   - Stimulus: 8 back-to-back ops, tags 0..7; out_ready toggles 1,0,1,0,...
   - Required: all 8 results emerge in tag order, none lost or duplicated; outputs stable during every out_ready=0 cycle; in_ready=0 exactly when out_valid && !out_ready.
5. Reset mid-stream:
   - Stimulus: accept 3 ops, then pulse reset for 1 cycle two cycles later.
   - Required: out_valid=0 and all outputs 0 on the cycle after the reset edge; none of the 3 results ever appears; a new op afterwards returns after 4 cycles.
6. Parameter sweep against a golden model:
   - Stimulus: WIDTH=32/GROUP=8 and WIDTH=8/GROUP=8, 10k random ops with random in_valid/out_ready.
   - Required: every result and flag matches the golden model; latencies are 4 and 1 cycles respectively.
